credit_acceptor: RTL and testbench
==================================

Name: credit_acceptor

Overview:
- Coin/credit front end that sits directly upstream of the dispenser FSM.
- Edge-detects coin-sensor and buy-button inputs and accumulates credit in a saturating-checked 3-bit register.
- Drives the dispenser's CIN[2:0] credit code and E enable; consumes the dispenser's dispense-complete indication.
- Deducts the price, then pays out change or a cancelled credit one unit per clock.

Parameters:
- MAX_CREDIT, 7: highest credit held; must be ≤ 7 (CIN is 3 bits).
- TIMEOUT_CYC, 50: idle cycles in ACCUM before auto-refund. Used only with CREDIT_AUTOREFUND_EN; counter is 8 bits; legal range 1..255.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- COIN  in  2  coin sensor: 00 none, 01 = 1 unit, 10 = 2 units, 11 = 4 units. Level held ≥ 1 cycle.
- BUY  in  1  purchase button, level.
- CANCEL  in  1  refund button, level.
- PRICE  in  3  price of the selected product in units; sampled on the accepted BUY.
- DONE  in  1  dispense complete from the dispenser FSM, level.
- CIN  out  3  current credit, to the dispenser.
- E  out  1  vend enable to the dispenser.
- RET  out  1  one-cycle pulse per unit returned.
- REJ  out  1  one-cycle pulse when a coin is rejected.
- NOFUND  out  1  one-cycle pulse when BUY is pressed with insufficient credit.
- BUSY  out  1  high in VEND and PAYOUT.

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RESET). RESET sampled high at a CLK edge overrides every other input.
- Reset values:
  - state = IDLE; CIN = 0; E = 0; RET = 0; REJ = 0; NOFUND = 0; BUSY = 0.
  - Latched price = 0; timeout counter = 0.
  - Edge registers preset to "active" (COIN prev = 11, BUY prev = 1, CANCEL prev = 1), so inputs held through reset produce no event until they return to 0.
- Events, evaluated on registered previous values:
  - coin event = COIN != 00 and prev COIN == 00.
  - buy event = rising edge of BUY.
  - cancel event = rising edge of CANCEL.
- Coin accept: on a coin event, if CIN + value ≤ MAX_CREDIT, CIN becomes CIN + value on the next edge (latency 1). Otherwise REJ pulses for 1 cycle and CIN is unchanged. Use a 4-bit sum for the compare.
- States:
  - IDLE (CIN = 0):
    - Accepted coin → ACCUM.
    - Buy event → NOFUND pulse; stay.
    - Cancel event → ignored.
  - ACCUM (CIN > 0), events in priority order:
    1. Cancel event → PAYOUT. A same-cycle coin is rejected (REJ); a same-cycle buy is ignored.
    2. Buy event with CIN ≥ PRICE → latch PRICE, go to VEND. The compare uses the pre-coin CIN; a same-cycle coin is still added if it fits.
    3. Buy event with CIN < PRICE → NOFUND pulse; a same-cycle coin is still processed.
    4. Coin event → accept or reject as above.
  - VEND:
    - E = 1; CIN holds its value; coin events are rejected (REJ); buy and cancel are ignored.
    - On DONE = 1: CIN ← CIN − latched price (never negative, by construction).
    - Next state is PAYOUT if the remainder > 0, else IDLE.
    - E drops on the same edge that leaves VEND.
  - PAYOUT:
    - Each cycle: RET = 1 and CIN decrements by 1.
    - When CIN == 1 the cycle's RET empties the credit and the next state is IDLE.
    - A payout of N units gives exactly N consecutive RET pulses.
    - Coins are rejected; buy and cancel are ignored.
- BUSY = 1 exactly when the state is VEND or PAYOUT.
- All outputs are registered; no combinational path from input to output.
- DONE outside VEND is ignored.
- A PRICE of 0 is legal: vend with no deduction, then the whole credit is paid out.

Optional Feature:
- CREDIT_AUTOREFUND_EN defined:
  - In ACCUM, the timeout counter increments each cycle with no coin, buy or cancel event; any such event clears it.
  - When the count reaches TIMEOUT_CYC → PAYOUT of the full credit.
  - The counter clears on leaving ACCUM.
- CREDIT_AUTOREFUND_EN undefined: no counter logic; ACCUM holds indefinitely.

Test Plan:
- Reset with COIN = 10 held, then release to 00 and reapply 10 → no credit during the hold; CIN = 2 one cycle after the reapplied edge.
- Coins 11, 10, 01 (each separated by 00) → CIN = 4, 6, 7. A further 01 → REJ pulse, CIN stays 7.
- CIN = 6, PRICE = 5, BUY edge → E = 1 next cycle. DONE after 3 cycles → E = 0, CIN = 1. Exactly 1 RET pulse, then IDLE with CIN = 0.
- CIN = 3, PRICE = 5, BUY → NOFUND 1 cycle, CIN = 3, E stays 0. Then CANCEL → 3 consecutive RET pulses, IDLE.
- Same cycle CANCEL + coin 01 with CIN = 2 → REJ pulse and 2 RET pulses. Same cycle BUY + coin 01 with CIN = 4, PRICE = 4 → VEND entered, CIN = 5.
- With CREDIT_AUTOREFUND_EN, TIMEOUT_CYC = 10: insert 01, wait 10 idle cycles → 1 RET pulse. Without the macro, after 300 cycles CIN is still 1.

Source files
------------

// File: rtl/credit_acceptor_if.sv
// Handshake bundle between the coin/credit front end and its surroundings.
// The master drives coin, button, price and dispense-complete levels; the slave returns credit status.
interface credit_acceptor_if;
   logic [1:0] COIN;
   logic       BUY;
   logic       CANCEL;
   logic [2:0] PRICE;
   logic       DONE;
   logic [2:0] CIN;
   logic       E;
   logic       RET;
   logic       REJ;
   logic       NOFUND;
   logic       BUSY;

   modport master (
      output COIN, BUY, CANCEL, PRICE, DONE,
      input  CIN, E, RET, REJ, NOFUND, BUSY
   );

   modport slave (
      input  COIN, BUY, CANCEL, PRICE, DONE,
      output CIN, E, RET, REJ, NOFUND, BUSY
   );
endinterface

// File: rtl/credit_acceptor.sv
// Coin/credit front end for the dispenser: edge-detects inputs, accumulates credit, vends and pays out change.
// Optional idle auto-refund in ACCUM is enabled by defining CREDIT_AUTOREFUND_EN.
module credit_acceptor #(
   parameter int unsigned MAX_CREDIT  = 7,
   parameter int unsigned TIMEOUT_CYC = 50
) (
   input  logic             CLK,
   input  logic             RESET,
   credit_acceptor_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCUM  = 2'd1,
      S_VEND   = 2'd2,
      S_PAYOUT = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] cin_q, cin_d;
   logic [2:0] price_q, price_d;
   logic       e_q, e_d;
   logic       ret_q, ret_d;
   logic       rej_q, rej_d;
   logic       nofund_q, nofund_d;
   logic       busy_q, busy_d;
   logic [1:0] coin_prev_q;
   logic       buy_prev_q;
   logic       cancel_prev_q;

   logic       coin_ev, buy_ev, cancel_ev;
   logic [2:0] coin_val;
   logic [3:0] coin_sum;
   logic       coin_fits;
   logic       buy_ok;
   logic [2:0] remainder;
   logic       tmo_hit;

   assign coin_ev   = (bus.COIN != 2'b00) && (coin_prev_q == 2'b00);
   assign buy_ev    = bus.BUY && !buy_prev_q;
   assign cancel_ev = bus.CANCEL && !cancel_prev_q;
   assign coin_sum  = {1'b0, cin_q} + {1'b0, coin_val};
   assign coin_fits = (coin_sum <= 4'(MAX_CREDIT));
   // Affordability uses the credit held before any same-cycle coin.
   assign buy_ok    = buy_ev && (cin_q >= bus.PRICE);
   assign remainder = cin_q - price_q;

   always_comb begin
      case (bus.COIN)
         2'b01:   coin_val = 3'd1;
         2'b10:   coin_val = 3'd2;
         2'b11:   coin_val = 3'd4;
         default: coin_val = 3'd0;
      endcase
   end

`ifdef CREDIT_AUTOREFUND_EN
   logic [7:0] tmo_q, tmo_d;
   logic       any_ev;

   assign any_ev  = coin_ev || buy_ev || cancel_ev;
   assign tmo_hit = !any_ev && ((tmo_q + 8'd1) == 8'(TIMEOUT_CYC));

   always_comb begin
      if ((state_q == S_ACCUM) && (state_d == S_ACCUM) && !any_ev) begin
         tmo_d = tmo_q + 8'd1;
      end else begin
         tmo_d = 8'd0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         tmo_q <= 8'd0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (coin_ev && coin_fits) state_d = S_ACCUM;
            else                      state_d = S_IDLE;
         end
         S_ACCUM: begin
            if (cancel_ev)    state_d = S_PAYOUT;
            else if (buy_ok)  state_d = S_VEND;
            else if (tmo_hit) state_d = S_PAYOUT;
            else              state_d = S_ACCUM;
         end
         S_VEND: begin
            if (bus.DONE) state_d = (remainder != 3'd0) ? S_PAYOUT : S_IDLE;
            else          state_d = S_VEND;
         end
         S_PAYOUT: begin
            if (cin_q == 3'd1) state_d = S_IDLE;
            else               state_d = S_PAYOUT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cin_d    = cin_q;
      price_d  = price_q;
      rej_d    = 1'b0;
      nofund_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            nofund_d = buy_ev;
            if (coin_ev && coin_fits) cin_d = coin_sum[2:0];
            else                      rej_d = coin_ev;
         end
         S_ACCUM: begin
            if (cancel_ev) begin
               rej_d = coin_ev;
            end else begin
               if (buy_ok) price_d  = bus.PRICE;
               else        nofund_d = buy_ev;
               if (coin_ev && coin_fits) cin_d = coin_sum[2:0];
               else                      rej_d = coin_ev;
            end
         end
         S_VEND: begin
            rej_d = coin_ev;
            if (bus.DONE) cin_d = remainder;
            else          cin_d = cin_q;
         end
         S_PAYOUT: begin
            rej_d = coin_ev;
            cin_d = cin_q - 3'd1;
         end
         default: begin
            cin_d = 3'd0;
         end
      endcase
      e_d    = (state_d == S_VEND);
      ret_d  = (state_d == S_PAYOUT);
      busy_d = (state_d == S_VEND) || (state_d == S_PAYOUT);
   end

   // Edge history presets to "active" so levels held through reset raise no event.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cin_q         <= 3'd0;
         price_q       <= 3'd0;
         e_q           <= 1'b0;
         ret_q         <= 1'b0;
         rej_q         <= 1'b0;
         nofund_q      <= 1'b0;
         busy_q        <= 1'b0;
         coin_prev_q   <= 2'b11;
         buy_prev_q    <= 1'b1;
         cancel_prev_q <= 1'b1;
      end else begin
         cin_q         <= cin_d;
         price_q       <= price_d;
         e_q           <= e_d;
         ret_q         <= ret_d;
         rej_q         <= rej_d;
         nofund_q      <= nofund_d;
         busy_q        <= busy_d;
         coin_prev_q   <= bus.COIN;
         buy_prev_q    <= bus.BUY;
         cancel_prev_q <= bus.CANCEL;
      end
   end

   assign bus.CIN    = cin_q;
   assign bus.E      = e_q;
   assign bus.RET    = ret_q;
   assign bus.REJ    = rej_q;
   assign bus.NOFUND = nofund_q;
   assign bus.BUSY   = busy_q;
endmodule

// File: tb/tb_credit_acceptor.sv
// Bench for credit_acceptor: directed scenarios plus random stimulus, scored against a transaction-level credit model.
module tb_credit_acceptor;
   localparam int MAXC = 7;
   localparam int TMO  = 10;
   localparam int M_IDLE = 0, M_ACCUM = 1, M_VEND = 2, M_PAYOUT = 3;

   typedef struct packed {
      logic [2:0] cin;
      logic       e;
      logic       ret;
      logic       rej;
      logic       nofund;
      logic       busy;
   } exp_t;

   logic CLK = 1'b0;
   logic RESET;
   credit_acceptor_if bus ();

   credit_acceptor #(.MAX_CREDIT(MAXC), .TIMEOUT_CYC(TMO)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: credit in units, a mode, latched price, idle count and last-seen input levels.
   int         m_mode, m_credit, m_price, m_tmo;
   logic [1:0] m_pc;
   logic       m_pb, m_pca;
   logic [1:0] cur_coin;

   function automatic void model_step(input logic rst, input logic [1:0] coin, input logic buy,
                                      input logic can, input logic [2:0] price, input logic done);
      bit   coin_ev, buy_ev, can_ev, fits, rej, nof;
      int   val;
      exp_t x;
      rej = 1'b0;
      nof = 1'b0;
      if (rst) begin
         m_mode = M_IDLE; m_credit = 0; m_price = 0; m_tmo = 0;
         m_pc = 2'b11; m_pb = 1'b1; m_pca = 1'b1;
      end else begin
         coin_ev = (coin != 2'b00) && (m_pc == 2'b00);
         buy_ev  = buy && !m_pb;
         can_ev  = can && !m_pca;
         val     = (coin == 2'b11) ? 4 : int'(coin);
         fits    = (m_credit + val) <= MAXC;
         case (m_mode)
            M_IDLE: begin
               nof = buy_ev;
               if (coin_ev) begin
                  if (fits) begin m_credit += val; m_mode = M_ACCUM; end
                  else rej = 1'b1;
               end
            end
            M_ACCUM: begin
               if (can_ev) begin
                  rej = coin_ev; m_mode = M_PAYOUT; m_tmo = 0;
               end else begin
                  if (buy_ev && m_credit >= int'(price)) begin m_price = int'(price); m_mode = M_VEND; end
                  else if (buy_ev) nof = 1'b1;
                  if (coin_ev) begin
                     if (fits) m_credit += val;
                     else rej = 1'b1;
                  end
                  if (m_mode == M_ACCUM) begin
`ifdef CREDIT_AUTOREFUND_EN
                     if (coin_ev || buy_ev) m_tmo = 0;
                     else begin
                        m_tmo++;
                        if (m_tmo == TMO) begin m_mode = M_PAYOUT; m_tmo = 0; end
                     end
`endif
                  end else m_tmo = 0;
               end
            end
            M_VEND: begin
               rej = coin_ev;
               if (done) begin
                  m_credit -= m_price;
                  m_mode = (m_credit > 0) ? M_PAYOUT : M_IDLE;
               end
            end
            default: begin
               rej = coin_ev;
               m_credit--;
               if (m_credit == 0) m_mode = M_IDLE;
            end
         endcase
         m_pc = coin; m_pb = buy; m_pca = can;
      end
      x.cin    = 3'(m_credit);
      x.e      = (m_mode == M_VEND);
      x.ret    = (m_mode == M_PAYOUT);
      x.rej    = rej;
      x.nofund = nof;
      x.busy   = (m_mode == M_VEND) || (m_mode == M_PAYOUT);
      sb.push_back(x);
   endfunction

   task automatic cyc(input logic rst, input logic [1:0] coin, input logic buy,
                      input logic can, input logic [2:0] price, input logic done);
      RESET      = rst;
      bus.COIN   = coin;
      bus.BUY    = buy;
      bus.CANCEL = can;
      bus.PRICE  = price;
      bus.DONE   = done;
      model_step(rst, coin, buy, can, price, done);
      @(negedge CLK);
   endtask

   task automatic step(input logic [1:0] coin, input logic buy, input logic can,
                       input logic [2:0] price, input logic done);
      cyc(1'b0, coin, buy, can, price, done);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(2'b00, 1'b0, 1'b0, 3'd0, 1'b0);
   endtask

   task automatic coin_in(input logic [1:0] c);
      step(c, 1'b0, 1'b0, 3'd0, 1'b0);
      step(2'b00, 1'b0, 1'b0, 3'd0, 1'b0);
   endtask

   // Scoreboard monitor: every cycle the DUT presents registered outputs, compare against the oldest expectation.
   initial begin
      exp_t x;
      exp_t act;
      forever begin
         @(posedge CLK);
         #1;
         if (sb.size() > 0) begin
            x   = sb.pop_front();
            act = {bus.CIN, bus.E, bus.RET, bus.REJ, bus.NOFUND, bus.BUSY};
            n_tests++;
            if (act !== x) begin
               n_fail++;
               $display("FAIL outputs t=%0t cin/e/ret/rej/nofund/busy got %b expected %b", $time, act, x);
            end
         end
      end
   end

   initial begin
      logic [1:0] rc;
      // Reset with COIN=10 held, release to 00 and reapply.
      for (int i = 0; i < 3; i++) cyc(1'b1, 2'b10, 1'b0, 1'b0, 3'd0, 1'b0);
      step(2'b10, 1'b0, 1'b0, 3'd0, 1'b0);
      step(2'b10, 1'b0, 1'b0, 3'd0, 1'b0);
      idle(2);
      coin_in(2'b10);
      step(2'b00, 1'b0, 1'b1, 3'd0, 1'b0);
      idle(4);
      // Fill to 7 and reject an overflowing coin.
      coin_in(2'b11); coin_in(2'b10); coin_in(2'b01); coin_in(2'b01);
      step(2'b00, 1'b0, 1'b1, 3'd0, 1'b0);
      idle(9);
      // Vend 5 from 6 with DONE after 3 cycles.
      coin_in(2'b11); coin_in(2'b10);
      step(2'b00, 1'b1, 1'b0, 3'd5, 1'b0);
      idle(3);
      step(2'b00, 1'b0, 1'b0, 3'd0, 1'b1);
      idle(3);
      // Insufficient funds, then cancel.
      coin_in(2'b10); coin_in(2'b01);
      step(2'b00, 1'b1, 1'b0, 3'd5, 1'b0);
      idle(1);
      step(2'b00, 1'b0, 1'b1, 3'd0, 1'b0);
      idle(5);
      // Cancel with same-cycle coin; buy with same-cycle coin.
      coin_in(2'b10);
      step(2'b01, 1'b0, 1'b1, 3'd0, 1'b0);
      idle(4);
      coin_in(2'b11);
      step(2'b01, 1'b1, 1'b0, 3'd4, 1'b0);
      idle(2);
      step(2'b00, 1'b0, 1'b0, 3'd0, 1'b1);
      idle(3);
      // Zero price vends then refunds the whole credit.
      coin_in(2'b10);
      step(2'b00, 1'b1, 1'b0, 3'd0, 1'b0);
      step(2'b00, 1'b0, 1'b0, 3'd0, 1'b1);
      idle(4);
      // Long idle in ACCUM with a single unit.
      coin_in(2'b01);
      idle(300);
      step(2'b00, 1'b0, 1'b1, 3'd0, 1'b0);
      idle(4);
      // Random traffic.
      cur_coin = 2'b00;
      for (int i = 0; i < 4000; i++) begin
         if (cur_coin == 2'b00) begin
            if ($urandom_range(0, 9) < 3) rc = 2'($urandom_range(1, 3));
            else rc = 2'b00;
         end else begin
            if ($urandom_range(0, 1) == 0) rc = cur_coin;
            else rc = 2'b00;
         end
         cur_coin = rc;
         cyc(($urandom_range(0, 299) == 0), rc, ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 19) == 0), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
      end
      idle(2);
      @(posedge CLK);
      #2;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain pending expectations got %0d expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
